// File: rtl/control_sequencer_pkg.sv
// ctrl_pkg: shared definitions for the control sequencer.
//   - opcode constants for the 4-bit instruction nibble
//   - T-state index constants (3-bit step values)
//   - bit positions inside the internal control word, plus a helper that
//     builds a one-hot control word from a bit position
package ctrl_pkg;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // T-state indices
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Control word bit positions
    localparam int CW_PC_INC     = 0;
    localparam int CW_PC_OUT     = 1;
    localparam int CW_PC_LOAD    = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_RAM_OUT    = 4;
    localparam int CW_RAM_LOAD   = 5;
    localparam int CW_IR_LOAD    = 6;
    localparam int CW_IR_OUT     = 7;
    localparam int CW_A_LOAD     = 8;
    localparam int CW_A_OUT      = 9;
    localparam int CW_B_LOAD     = 10;
    localparam int CW_ALU_OUT    = 11;
    localparam int CW_ALU_SUB    = 12;
    localparam int CW_FLAGS_LOAD = 13;
    localparam int CW_OUT_LOAD   = 14;
    localparam int CW_W          = 15;

    typedef logic [CW_W-1:0] cw_t;

    // One-hot control word with only bit 'pos' set
    function automatic cw_t cw_bit(input int pos);
        cw_t m;
        m      = {CW_W{1'b0}};
        m[pos] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: groups the sequencer's instruction/flag inputs and
// its control-line outputs.
//   master : the sequencer (drives controls, step, halted)
//   slave  : the datapath / instruction source (drives run, instruction, flags)
interface control_sequencer_if;
    logic       run;
    logic [3:0] instruction;
    logic       carry_flag;
    logic       zero_flag;
    logic       pc_inc;
    logic       pc_out;
    logic       pc_load;
    logic       mar_load;
    logic       ram_out;
    logic       ram_load;
    logic       ir_load;
    logic       ir_out;
    logic       a_load;
    logic       a_out;
    logic       b_load;
    logic       alu_out;
    logic       alu_sub;
    logic       flags_load;
    logic       out_load;
    logic [2:0] step;
    logic       halted;

    modport master (
        input  run, instruction, carry_flag, zero_flag,
        output pc_inc, pc_out, pc_load, mar_load, ram_out, ram_load,
               ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, step, halted
    );

    modport slave (
        output run, instruction, carry_flag, zero_flag,
        input  pc_inc, pc_out, pc_load, mar_load, ram_out, ram_load,
               ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, step, halted
    );
endinterface

// File: rtl/control_sequencer_step_counter.sv
// step_counter: T-state counter that counts 0..NUM_STEPS-1 and wraps.
//   clk   : system clock
//   reset : synchronous active-high reset (forces step to 0)
//   en    : advance enable; when low the step holds
//   step  : current T-state index
module step_counter #(
    parameter int NUM_STEPS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [2:0] step
);
    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    logic [2:0] step_q;
    logic [2:0] step_d;

    // Next-step computation: increment with wrap, or hold
    always_comb begin
        step_d = step_q;
        if (en) begin
            if (step_q == LAST_STEP) begin
                step_d = 3'd0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end else begin
            step_d = step_q;
        end
    end

    // Step register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= 3'd0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microcoded T-state sequencer for a simple 8-bit CPU.
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous active-high reset (step=0, halted=0, controls 0)
//   bus   : control_sequencer_if.master -- run/instruction/flags in,
//           all control lines plus step and halted out
// Controls are combinational from (step, instruction, flags) and are forced
// low while reset, run=0 or halted. T0/T1 fetch is common to every opcode;
// execute microinstructions occupy T2..T4 and any later steps are idle.
// Optional macro SEQ_JUMP_EN enables JMP/JC/JZ; without it those opcodes
// behave as NOP and pc_load stays 0.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int NUM_STEPS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    control_sequencer_if.master   bus
);

    logic [2:0] step_s;
    logic       halted_q;
    logic       halted_d;
    logic       step_en_s;
    logic       active_s;
    cw_t        cw_s;

    // Step only advances while running and not halted
    assign step_en_s = bus.run & ~halted_q;

    step_counter #(.NUM_STEPS(NUM_STEPS)) u_step_counter (
        .clk   (clk),
        .reset (reset),
        .en    (step_en_s),
        .step  (step_s)
    );

    // Halt latches on the edge that leaves T2 of an HLT; the counter moves to
    // T3 on that same edge and then freezes because step_en_s drops.
    always_comb begin
        halted_d = halted_q;
        if (step_en_s && (step_s == T2) && (bus.instruction == OP_HLT)) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end
    end

    // Halt flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign active_s = ~reset & bus.run & ~halted_q;

    // Microinstruction decode; each step drives at most one *_out line
    always_comb begin
        cw_s = {CW_W{1'b0}};
        if (active_s) begin
            case (step_s)
                T0: cw_s = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
                T1: cw_s = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
                T2: begin
                    case (bus.instruction)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA:
                            cw_s = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
                        OP_LDI:
                            cw_s = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
                        OP_OUT:
                            cw_s = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
`ifdef SEQ_JUMP_EN
                        OP_JMP:
                            cw_s = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                        OP_JC: begin
                            if (bus.carry_flag) begin
                                cw_s = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                            end else begin
                                cw_s = {CW_W{1'b0}};
                            end
                        end
                        OP_JZ: begin
                            if (bus.zero_flag) begin
                                cw_s = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                            end else begin
                                cw_s = {CW_W{1'b0}};
                            end
                        end
`endif
                        default: cw_s = {CW_W{1'b0}};
                    endcase
                end
                T3: begin
                    case (bus.instruction)
                        OP_LDA:         cw_s = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
                        OP_ADD, OP_SUB: cw_s = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
                        OP_STA:         cw_s = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_LOAD);
                        default:        cw_s = {CW_W{1'b0}};
                    endcase
                end
                T4: begin
                    case (bus.instruction)
                        OP_ADD:  cw_s = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD)
                                      | cw_bit(CW_FLAGS_LOAD);
                        OP_SUB:  cw_s = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD)
                                      | cw_bit(CW_FLAGS_LOAD) | cw_bit(CW_ALU_SUB);
                        default: cw_s = {CW_W{1'b0}};
                    endcase
                end
                default: cw_s = {CW_W{1'b0}};
            endcase
        end else begin
            cw_s = {CW_W{1'b0}};
        end
    end

    assign bus.pc_inc     = cw_s[CW_PC_INC];
    assign bus.pc_out     = cw_s[CW_PC_OUT];
    assign bus.pc_load    = cw_s[CW_PC_LOAD];
    assign bus.mar_load   = cw_s[CW_MAR_LOAD];
    assign bus.ram_out    = cw_s[CW_RAM_OUT];
    assign bus.ram_load   = cw_s[CW_RAM_LOAD];
    assign bus.ir_load    = cw_s[CW_IR_LOAD];
    assign bus.ir_out     = cw_s[CW_IR_OUT];
    assign bus.a_load     = cw_s[CW_A_LOAD];
    assign bus.a_out      = cw_s[CW_A_OUT];
    assign bus.b_load     = cw_s[CW_B_LOAD];
    assign bus.alu_out    = cw_s[CW_ALU_OUT];
    assign bus.alu_sub    = cw_s[CW_ALU_SUB];
    assign bus.flags_load = cw_s[CW_FLAGS_LOAD];
    assign bus.out_load   = cw_s[CW_OUT_LOAD];
    assign bus.step       = step_s;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: a table-driven reference model predicts
// step, halted and every control line each cycle; predictions go into a
// queue and a separate monitor pops and compares on the falling edge.
module tb_control_sequencer;

    localparam int NS = 6;

    typedef struct packed {
        logic pc_inc, pc_out, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
        logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load;
    } ctl_t;

    typedef struct packed {
        logic [2:0] step;
        logic       halted;
        ctl_t       ctl;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer #(.NUM_STEPS(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Microprogram table: prog[opcode][step]
    ctl_t prog [16][8];
    obs_t exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   m_step;
    logic m_halt;
    int   cyc_no = 0;

    function automatic ctl_t lookup(input int s, input logic [3:0] op,
                                    input logic c, input logic z);
        ctl_t e;
        e = prog[op][s];
        // Conditional jumps skip their execute step when the flag is clear
        if (s >= 2 && ((op == 4'd7 && !c) || (op == 4'd8 && !z))) e = '0;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic rn, input logic [3:0] op,
                       input logic c, input logic z);
        obs_t e;
        @(posedge clk);
        #1;
        reset           = r;
        bus.run         = rn;
        bus.instruction = op;
        bus.carry_flag  = c;
        bus.zero_flag   = z;
        e.step   = 3'(m_step);
        e.halted = m_halt;
        e.ctl    = (r || !rn || m_halt) ? '0 : lookup(m_step, op, c, z);
        exp_q.push_back(e);
        if (r) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (rn && !m_halt) begin
            if (m_step == 2 && op == 4'hF) m_halt = 1'b1;
            m_step = (m_step + 1) % NS;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
        int guard;
        guard = 0;
        while (m_step != 0 && !m_halt && guard < 2 * NS) begin
            cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
            guard++;
        end
        repeat (NS) cyc(1'b0, 1'b1, op, c, z);
    endtask

    // Monitor: compare DUT against the oldest prediction every falling edge
    initial begin
        obs_t e;
        obs_t g;
        int   drivers;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_no++;
                g.step   = bus.step;
                g.halted = bus.halted;
                g.ctl    = {bus.pc_inc, bus.pc_out, bus.pc_load, bus.mar_load,
                            bus.ram_out, bus.ram_load, bus.ir_load, bus.ir_out,
                            bus.a_load, bus.a_out, bus.b_load, bus.alu_out,
                            bus.alu_sub, bus.flags_load, bus.out_load};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL seq_state cycle=%0d got step=%0d halted=%b ctl=%b expected step=%0d halted=%b ctl=%b",
                             cyc_no, g.step, g.halted, g.ctl, e.step, e.halted, e.ctl);
                end
                drivers = int'(bus.pc_out) + int'(bus.ram_out) + int'(bus.ir_out)
                        + int'(bus.a_out) + int'(bus.alu_out);
                total++;
                if (drivers > 1) begin
                    bad++;
                    $display("FAIL bus_driver cycle=%0d got %0d drivers expected at most 1",
                             cyc_no, drivers);
                end
            end
        end
    end

    initial begin
        logic [3:0] op;
        logic       rr;
        // Fetch is common to every opcode
        for (int o = 0; o < 16; o++)
            for (int s = 0; s < 8; s++) prog[o][s] = '0;
        for (int o = 0; o < 16; o++) begin
            prog[o][0].pc_out = 1'b1; prog[o][0].mar_load = 1'b1;
            prog[o][1].ram_out = 1'b1; prog[o][1].ir_load = 1'b1; prog[o][1].pc_inc = 1'b1;
        end
        // LDA
        prog[1][2].ir_out = 1'b1; prog[1][2].mar_load = 1'b1;
        prog[1][3].ram_out = 1'b1; prog[1][3].a_load = 1'b1;
        // ADD and SUB
        for (int o = 2; o <= 3; o++) begin
            prog[o][2].ir_out = 1'b1; prog[o][2].mar_load = 1'b1;
            prog[o][3].ram_out = 1'b1; prog[o][3].b_load = 1'b1;
            prog[o][4].alu_out = 1'b1; prog[o][4].a_load = 1'b1; prog[o][4].flags_load = 1'b1;
        end
        prog[3][4].alu_sub = 1'b1;
        // STA
        prog[4][2].ir_out = 1'b1; prog[4][2].mar_load = 1'b1;
        prog[4][3].a_out = 1'b1; prog[4][3].ram_load = 1'b1;
        // LDI
        prog[5][2].ir_out = 1'b1; prog[5][2].a_load = 1'b1;
        // OUT
        prog[14][2].a_out = 1'b1; prog[14][2].out_load = 1'b1;
`ifdef SEQ_JUMP_EN
        for (int o = 6; o <= 8; o++) begin
            prog[o][2].ir_out = 1'b1; prog[o][2].pc_load = 1'b1;
        end
`endif

        reset = 1'b1; bus.run = 1'b0; bus.instruction = 4'h0;
        bus.carry_flag = 1'b0; bus.zero_flag = 1'b0;
        @(posedge clk);
        m_step = 0;
        m_halt = 1'b0;

        // Reset for two cycles then NOP cycle with wrap
        repeat (2) cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        // ADD, SUB and the remaining defined/undefined opcodes
        run_instr(4'h2, 1'b0, 1'b0);
        run_instr(4'h3, 1'b1, 1'b1);
        run_instr(4'h4, 1'b0, 1'b0);
        run_instr(4'h5, 1'b0, 1'b0);
        run_instr(4'hE, 1'b0, 1'b0);
        run_instr(4'h9, 1'b1, 1'b1);
        // LDA stalled at T3 for four cycles
        run_instr(4'h0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
        repeat (NS - 3) cyc(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        // ADD aborted by reset at T4
        repeat (4) cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        // Jumps (NOP-like when the jump feature is not built)
        run_instr(4'h7, 1'b0, 1'b1);
        run_instr(4'h7, 1'b1, 1'b0);
        run_instr(4'h8, 1'b1, 1'b0);
        run_instr(4'h8, 1'b0, 1'b1);
        run_instr(4'h6, 1'b0, 1'b0);
        // HLT, ten frozen cycles, then reset
        run_instr(4'h0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b1, 4'hF, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

        // Randomized traffic; opcode changes only at T0 like a real IR
        op = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if (m_step == 0) op = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 59) == 0) || (m_halt && $urandom_range(0, 7) == 0);
            cyc(rr, ($urandom_range(0, 9) != 0), op,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 6, T-states per instruction cycle; legal range 5..8.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  step enable; low = hold T-state and suppress all controls.
REQ-005 instruction  input  4  opcode nibble from the instruction register.
REQ-006 carry_flag, zero_flag  input  1 each  ALU flags (used only by conditional jumps).
REQ-007 pc_inc, pc_out, pc_load  output  1 each  program counter controls.
REQ-008 mar_load, ram_out, ram_load, ir_load, ir_out  output  1 each  memory/IR controls.
REQ-009 a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load  output  1 each  datapath controls.
REQ-010 step  output  3  current T-state index.
REQ-011 halted  output  1  high once HLT has executed.

Function
REQ-012 step SHALL advance by 1 each clk edge when run=1 and halted=0, and wrap from NUM_STEPS-1 to 0.
REQ-013 Controls SHALL be combinational from (step, instruction, flags) and forced to 0 while reset=1, run=0 or halted=1.
REQ-014 T0: pc_out, mar_load. T1: ram_out, ir_load, pc_inc (for every opcode).
REQ-015 Opcode decode SHALL use instruction as sampled from T2 onward (IR loaded at end of T1).
REQ-016 LDA 0001: T2 ir_out, mar_load; T3 ram_out, a_load.
REQ-017 ADD 0010: T2 ir_out, mar_load; T3 ram_out, b_load; T4 alu_out, a_load, flags_load.
REQ-018 SUB 0011: as ADD, with alu_sub also asserted in T4.
REQ-019 STA 0100: T2 ir_out, mar_load; T3 a_out, ram_load.
REQ-020 LDI 0101: T2 ir_out, a_load.
REQ-021 OUT 1110: T2 a_out, out_load.
REQ-022 HLT 1111: halted SHALL set at the T2 edge; step freezes at 3; only reset clears it.
REQ-023 NOP 0000 and all undefined opcodes SHALL assert nothing in T2..NUM_STEPS-1.
REQ-024 Steps beyond the last microinstruction of an opcode SHALL assert nothing; the cycle does not terminate early.
REQ-025 At most one *_out signal SHALL be high in any step (single bus driver).
REQ-026 run deasserted mid-instruction SHALL resume at the same step with no lost or repeated microinstruction.

Reset
REQ-027 On a clk edge with reset=1: step=0, halted=0; all controls read 0 during that cycle.
REQ-028 Reset SHALL take priority over run and halted; reset mid-instruction aborts it and restarts at T0.

Configuration
REQ-029 With SEQ_JUMP_EN defined: JMP 0110 T2 ir_out, pc_load; JC 0111 same only if carry_flag=1; JZ 1000 same only if zero_flag=1.
REQ-030 Without SEQ_JUMP_EN: opcodes 0110/0111/1000 SHALL decode as NOP; ports remain present; pc_load is tied 0.

Structure
REQ-031 Shared package ctrl_pkg SHALL hold opcode constants, T-state index constants and control-word bit positions.
REQ-032 The T-state counter SHALL be a sub-module step_counter (clk, reset, en, wrap at NUM_STEPS-1, step output).

Verification
REQ-033 reset high 2 cycles, then run=1, instruction=0000 -> step 0,1,2,3,4,5,0; only T0/T1 controls asserted.
REQ-034 instruction=0010, run=1 -> T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load+flags_load, alu_sub=0; 0011 same with alu_sub=1 at T4.
REQ-035 instruction=1111 -> halted=1 after T2 edge, step stays 3, all controls 0 for 10 cycles; reset -> step=0, halted=0.
REQ-036 run=0 at T3 of LDA for 4 cycles -> step holds 3, controls 0; run=1 -> ram_out+a_load then T4.
REQ-037 SEQ_JUMP_EN defined, instruction=0111, carry_flag=0 -> no pc_load at T2; carry_flag=1 -> ir_out+pc_load at T2; macro undefined -> pc_load never asserted.
REQ-038 reset asserted at T4 of ADD -> next cycle step=0, no a_load/flags_load issued.
